// File: rtl/de2_115_sw_pkg.sv
// Shared defaults and sizing helper for the slide-switch debouncer.
// Counter widths are derived here so the top and the per-bit cell agree.
package de2_115_sw_pkg;

    localparam int SW_WIDTH        = 18;
    localparam int SW_TICK_DIV     = 50000;
    localparam int SW_STABLE_TICKS = 16;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/de2_115_debounce_cell.sv
// One switch bit: accepts a new level after it holds for STABLE_TICKS ticks,
// issuing a single-cycle pulse in the cycle the accepted level appears.
module de2_115_debounce_cell
    import de2_115_sw_pkg::*;
#(
    parameter int   STABLE_TICKS = SW_STABLE_TICKS,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s2_bit,
    input  logic tick,
    output logic stable,
    output logic pulse
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        // Any return to the accepted level discards accumulated progress.
        if (s2_bit == stable_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_bit;
                cnt_d    = '0;
                pulse_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= RESET_BIT;
            pulse_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    assign stable = stable_q;
    assign pulse  = pulse_q;

endmodule

// File: rtl/de2_115_sw_debouncer.sv
// Switch conditioning: two-flop synchroniser, shared tick prescaler and one
// debounce cell per bit, giving the PIO a clean level and a change strobe.
module de2_115_sw_debouncer
    import de2_115_sw_pkg::*;
#(
    parameter int               WIDTH        = SW_WIDTH,
    parameter int               TICK_DIV     = SW_TICK_DIV,
    parameter int               STABLE_TICKS = SW_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] change_pulse,
    output logic             tick
);

    localparam int            PW         = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;

    // tick is registered, so it is high while presc_q sits at its last value.
    always_comb begin
        s1_d    = in_raw;
        s2_d    = s1_q;
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q    <= RESET_VALUE;
            s2_q    <= RESET_VALUE;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        de2_115_debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_BIT   (RESET_VALUE[i])
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .s2_bit (s2_q[i]),
            .tick   (tick_q),
            .stable (out_port[i]),
            .pulse  (change_pulse[i])
        );
    end

endmodule

// File: tb/tb_de2_115_sw_debouncer.sv
// Bench for the switch debouncer: window-based reference model for the main
// instance, plus a second instance exercising the fastest configuration.
module tb_de2_115_sw_debouncer;

    localparam int          W  = 18;
    localparam int          TD = 4;
    localparam int          ST = 3;
    localparam logic [17:0] RV = 18'h0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  in_raw = '0;
    logic [W-1:0]  out_port, change_pulse;
    logic          tick;

    logic          reset6_n = 1'b0;
    logic [W-1:0]  in_raw6 = 18'h3FFFF;
    logic [W-1:0]  out6, pulse6;
    logic          tick6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    de2_115_sw_debouncer #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset_n(reset_n), .in_raw(in_raw),
        .out_port(out_port), .change_pulse(change_pulse), .tick(tick)
    );

    de2_115_sw_debouncer #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VALUE(18'h3FFFF)) dut6 (
        .clk(clk), .reset_n(reset6_n), .in_raw(in_raw6),
        .out_port(out6), .change_pulse(pulse6), .tick(tick6)
    );

    // Reference model: cycle k counts from the last reset edge. A bit accepts
    // a new level once ST ticks have fallen since it last matched the output.
    int           k;
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out, m_pulse;
    logic         m_tick;
    int           last_eq[W];

    function automatic int ticks_upto(input int x);
        if (x < 0) return 0;
        return (x + 1) / TD - ((TD == 1) ? 1 : 0);
    endfunction

    function automatic logic tick_at(input int x);
        return (ticks_upto(x) - ticks_upto(x - 1)) == 1;
    endfunction

    task automatic do_reset(input logic [W-1:0] v);
        reset_n = 1'b0;
        in_raw  = v;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        k = 0;
        hist.delete();
        m_out   = RV;
        m_pulse = '0;
        m_tick  = 1'b0;
        for (int i = 0; i < W; i++) last_eq[i] = -1;
    endtask

    task automatic step(input logic [W-1:0] v);
        logic [W-1:0] s2;
        in_raw = v;
        hist.push_back(v);
        @(posedge clk);
        s2 = (k >= 2) ? hist[k-2] : RV;
        m_pulse = '0;
        for (int i = 0; i < W; i++) begin
            if (s2[i] == m_out[i]) begin
                last_eq[i] = k;
            end else if (tick_at(k) && (ticks_upto(k) - ticks_upto(last_eq[i])) == ST) begin
                m_out[i]   = s2[i];
                m_pulse[i] = 1'b1;
                last_eq[i] = k;
            end
        end
        k++;
        m_tick = tick_at(k);
        #1;
    endtask

    task automatic idle_random();
        int n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) step(in_raw);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_raw = W'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out_port !== RV || change_pulse !== '0 || tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_state out=%h pulse=%h tick=%b expected out=%h pulse=0 tick=0",
                         out_port, change_pulse, tick, RV);
            end
        end
    endtask

    task automatic test_single_rise();
        int lat = 0, pulses = 0;
        logic [W-1:0] pval = '0;
        do_reset('0);
        idle_random();
        for (int j = 1; j <= 30; j++) begin
            step(18'h00001);
            checks++;
            if (out_port !== m_out || change_pulse !== m_pulse || tick !== m_tick) begin
                failures++;
                $display("FAIL rise_model j=%0d out=%h/%h pulse=%h/%h tick=%b/%b",
                         j, out_port, m_out, change_pulse, m_pulse, tick, m_tick);
            end
            if (change_pulse != '0) begin pulses++; pval = change_pulse; if (lat == 0) lat = j; end
        end
        checks++;
        if (lat < 11 || lat > 14) begin failures++; $display("FAIL rise_latency got=%0d want 11..14", lat); end
        checks++;
        if (pulses != 1 || pval !== 18'h00001) begin
            failures++; $display("FAIL rise_pulse count=%0d val=%h want count=1 val=00001", pulses, pval);
        end
        checks++;
        if (out_port !== 18'h00001) begin failures++; $display("FAIL rise_final out=%h want 00001", out_port); end
    endtask

    task automatic test_bounce();
        int lat = 0, pulses = 0;
        do_reset('0);
        idle_random();
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) begin
                step((r % 2 == 0) ? 18'h00008 : 18'h00000);
                checks++;
                if (out_port !== m_out || change_pulse !== m_pulse) begin
                    failures++;
                    $display("FAIL bounce_model r=%0d out=%h/%h pulse=%h/%h", r, out_port, m_out, change_pulse, m_pulse);
                end
                if (change_pulse[3]) pulses++;
            end
        end
        for (int j = 1; j <= 30; j++) begin
            step(18'h00008);
            checks++;
            if (out_port !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL bounce_settle_model j=%0d out=%h/%h pulse=%h/%h", j, out_port, m_out, change_pulse, m_pulse);
            end
            if (change_pulse[3]) begin pulses++; if (lat == 0) lat = j; end
        end
        checks++;
        if (lat < 11 || lat > 14) begin failures++; $display("FAIL bounce_latency got=%0d want 11..14", lat); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL bounce_pulses got=%0d want 1", pulses); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset('0);
        idle_random();
        for (int j = 0; j < 35; j++) begin
            step((j < 5) ? 18'h00020 : 18'h00000);
            checks++;
            if (out_port !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL glitch_model j=%0d out=%h/%h pulse=%h/%h", j, out_port, m_out, change_pulse, m_pulse);
            end
            if (change_pulse != '0 || out_port != '0) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL glitch_quiet activity_cycles=%0d want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        for (int ph = 0; ph < 2; ph++) begin
            int lat = 0, pulses = 0;
            logic [W-1:0] pval = '0;
            logic [W-1:0] v = (ph == 0) ? 18'h20001 : 18'h00000;
            if (ph == 0) do_reset('0);
            idle_random();
            for (int j = 1; j <= 30; j++) begin
                step(v);
                checks++;
                if (out_port !== m_out || change_pulse !== m_pulse || tick !== m_tick) begin
                    failures++;
                    $display("FAIL simul_model ph=%0d j=%0d out=%h/%h pulse=%h/%h", ph, j, out_port, m_out, change_pulse, m_pulse);
                end
                if (change_pulse != '0) begin pulses++; pval = change_pulse; if (lat == 0) lat = j; end
            end
            checks++;
            if (lat < 11 || lat > 14 || pulses != 1 || pval !== 18'h20001) begin
                failures++;
                $display("FAIL simul_pulse ph=%0d lat=%0d count=%0d val=%h want lat 11..14 count=1 val=20001", ph, lat, pulses, pval);
            end
            checks++;
            if (out_port !== v) begin failures++; $display("FAIL simul_final ph=%0d out=%h want %h", ph, out_port, v); end
        end
    endtask

    task automatic test_reset_mid_count();
        int seen = 0, lat = 0, guard = 0;
        do_reset('0);
        idle_random();
        while (seen < 2 && guard < 40) begin
            step(18'h00004);
            guard++;
            if (m_tick) seen++;
        end
        checks++;
        if (seen != 2 || out_port !== '0) begin
            failures++; $display("FAIL midreset_pre ticks=%0d out=%h want ticks=2 out=0", seen, out_port);
        end
        do_reset(18'h00004);
        checks++;
        if (out_port !== '0 || change_pulse !== '0) begin
            failures++; $display("FAIL midreset_release out=%h pulse=%h want 0 0", out_port, change_pulse);
        end
        for (int j = 1; j <= 30; j++) begin
            step(18'h00004);
            checks++;
            if (out_port !== m_out || change_pulse !== m_pulse) begin
                failures++;
                $display("FAIL midreset_model j=%0d out=%h/%h pulse=%h/%h", j, out_port, m_out, change_pulse, m_pulse);
            end
            if (change_pulse[2] && lat == 0) lat = j;
        end
        checks++;
        if (lat < 11 || lat > 14) begin failures++; $display("FAIL midreset_latency got=%0d want 11..14", lat); end
    endtask

    task automatic test_fast_config();
        reset6_n = 1'b0;
        in_raw6  = 18'h3FFFF;
        repeat (2) @(posedge clk);
        #1;
        reset6_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tick6 !== 1'b1 || out6 !== 18'h3FFFF || pulse6 !== '0) begin
                failures++;
                $display("FAIL fast_idle j=%0d tick=%b out=%h pulse=%h want 1 3ffff 0", j, tick6, out6, pulse6);
            end
        end
        in_raw6 = 18'h3FFFE;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out6 !== ((e >= 3) ? 18'h3FFFE : 18'h3FFFF) ||
                pulse6 !== ((e == 3) ? 18'h00001 : 18'h00000) || tick6 !== 1'b1) begin
                failures++;
                $display("FAIL fast_fall edge=%0d out=%h pulse=%h tick=%b", e, out6, pulse6, tick6);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_mid_count();
        test_fast_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
